// File: rtl/hpm_counter_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hpm_counter_unit_pkg
// Description : Shared CSR address constants and decode types for the
//               performance-counter block.
//               No ports. Exports counter CSR addresses (low and high halves,
//               machine and user views), the first event-counter index and
//               the CSR access-class enum used by the top-level decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package hpm_counter_unit_pkg;

    localparam logic [11:0] CSR_MCOUNTEREN    = 12'h306;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_MHPMCOUNTER3H = 12'hB83;

    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_TIME          = 12'hC01;
    localparam logic [11:0] CSR_INSTRET       = 12'hC02;
    localparam logic [11:0] CSR_HPMCOUNTER3   = 12'hC03;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
    localparam logic [11:0] CSR_TIMEH         = 12'hC81;
    localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
    localparam logic [11:0] CSR_HPMCOUNTER3H  = 12'hC83;

    // CSR index of the first programmable event counter.
    localparam int HPM_BASE_IDX = 3;

    // Which register group an incoming CSR address falls into.
    typedef enum logic [2:0] {
        ACC_NONE = 3'd0,   // not in the map
        ACC_MCNT = 3'd1,   // Bxx / B8x machine counters
        ACC_UCNT = 3'd2,   // Cxx / C8x user read-only shadows
        ACC_CEN  = 3'd3,   // mcounteren
        ACC_INH  = 3'd4    // mcountinhibit
    } csr_acc_e;

endpackage : hpm_counter_unit_pkg
`default_nettype wire

// File: rtl/hpm_counter_unit_counter.sv
`default_nettype none
// ============================================================================
// Module      : hpm_counter
// Description : One CNT_WIDTH-bit performance counter with per-cycle
//               increment, inhibit and independent low/high half writes.
//               A write in a cycle replaces the increment for that cycle.
// Ports       : clk, reset_n         - clock, async active-low reset
//               inc_i                - amount to add this cycle
//               inhibit_i            - freeze counting (writes still apply)
//               we_lo_i / we_hi_i    - replace bits [XLEN-1:0] / [CNT-1:XLEN]
//               wdata_i              - CSR write data
//               cnt_o                - current counter value
// Revision    : 1.0 - initial release
// ============================================================================
module hpm_counter #(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 64,
    parameter int INC_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [INC_WIDTH-1:0] inc_i,
    input  logic                 inhibit_i,
    input  logic                 we_lo_i,
    input  logic                 we_hi_i,
    input  logic [XLEN-1:0]      wdata_i,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    localparam int c_HI_W = CNT_WIDTH - XLEN;

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (we_lo_i || we_hi_i) begin
            // The written value lands exactly; no increment this cycle.
            if (we_lo_i) cnt_d[XLEN-1:0]         = wdata_i;
            if (we_hi_i) cnt_d[CNT_WIDTH-1:XLEN] = wdata_i[c_HI_W-1:0];
        end else if (!inhibit_i) begin
            cnt_d = cnt_q + CNT_WIDTH'(inc_i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule : hpm_counter
`default_nettype wire

// File: rtl/hpm_counter_unit.sv
`default_nettype none
// ============================================================================
// Module      : hpm_counter_unit
// Description : mcycle, minstret and NB_HPM event counters with
//               mcountinhibit / mcounteren, served over a one-cycle CSR
//               request/response port with privilege checks.
// Ports       : clk, reset_n          - clock, async active-low reset
//               event_i[k]            - increments counter 3+k
//               retire_cnt_i          - instructions retired this cycle
//               priv_m_i              - 1 = machine mode, 0 = user mode
//               csr_req_i/we/addr/wdata - CSR request
//               csr_rvalid_o/rdata_o/err_o - registered response
// Revision    : 1.0 - initial release
// ============================================================================
module hpm_counter_unit
    import hpm_counter_unit_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int CNT_WIDTH    = 64,
    parameter int NB_HPM       = 14,
    parameter int RETIRE_WIDTH = 2
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NB_HPM-1:0]                 event_i,
    input  logic [$clog2(RETIRE_WIDTH+1)-1:0] retire_cnt_i,
    input  logic                              priv_m_i,
    input  logic                              csr_req_i,
    input  logic                              csr_we_i,
    input  logic [11:0]                       csr_addr_i,
    input  logic [XLEN-1:0]                   csr_wdata_i,
    output logic                              csr_rvalid_o,
    output logic [XLEN-1:0]                   csr_rdata_o,
    output logic                              csr_err_o
);

    localparam int c_RET_W   = $clog2(RETIRE_WIDTH+1);
    localparam int c_NB_SLOT = NB_HPM + 2;

    // Writable bits of mcounteren/mcountinhibit: 0 and 2..NB_HPM+2.
    localparam logic [63:0]     c_ONE64    = 64'd1;
    localparam logic [63:0]     c_IMPL64   = (c_ONE64 << (NB_HPM + 3)) - 64'd1;
    localparam logic [XLEN-1:0] c_CSR_MASK = c_IMPL64[XLEN-1:0] & ~XLEN'(2);

    logic [4:0]           w_idx;
    logic                 w_hi;
    csr_acc_e             w_acc;
    logic                 w_err;
    logic [XLEN-1:0]      w_rd_val;
    logic                 w_wr_ok;
    logic                 w_cnt_wr;
    logic [CNT_WIDTH-1:0] w_cnt [c_NB_SLOT];
    logic [c_NB_SLOT-1:0] w_hit;
    logic [CNT_WIDTH-1:0] w_cnt_sel;

    logic [XLEN-1:0] mcounteren_q,    mcounteren_d;
    logic [XLEN-1:0] mcountinhibit_q, mcountinhibit_d;
    logic            rvalid_q,        rvalid_d;
    logic [XLEN-1:0] rdata_q,         rdata_d;
    logic            err_q,           err_d;

    assign w_idx = csr_addr_i[4:0];
    assign w_hi  = csr_addr_i[7];

    // Slot 0 = mcycle (idx 0), slot 1 = minstret (idx 2), slot 2+k = idx 3+k.
    for (genvar s = 0; s < c_NB_SLOT; s++) begin : g_slot
        localparam int c_IDX = (s == 0) ? 0 : s + 1;
        logic [c_RET_W-1:0] w_inc;

        if (s == 0) begin : g_cycle
            assign w_inc = c_RET_W'(1);
        end else if (s == 1) begin : g_instret
            assign w_inc = retire_cnt_i;
        end else begin : g_event
            assign w_inc = c_RET_W'(event_i[c_IDX-HPM_BASE_IDX]);
        end

        assign w_hit[s] = (w_idx == 5'(c_IDX));

        hpm_counter #(
            .XLEN      (XLEN),
            .CNT_WIDTH (CNT_WIDTH),
            .INC_WIDTH (c_RET_W)
        ) u_cnt (
            .clk       (clk),
            .reset_n   (reset_n),
            .inc_i     (w_inc),
            .inhibit_i (mcountinhibit_q[c_IDX]),
            .we_lo_i   (w_cnt_wr & ~w_hi & w_hit[s]),
            .we_hi_i   (w_cnt_wr &  w_hi & w_hit[s]),
            .wdata_i   (csr_wdata_i),
            .cnt_o     (w_cnt[s])
        );
    end

    // Reserved indices hit no slot and therefore read as zero.
    always_comb begin
        w_cnt_sel = '0;
        for (int s = 0; s < c_NB_SLOT; s++) begin
            if (w_hit[s]) w_cnt_sel = w_cnt[s];
        end
    end

    always_comb begin
        w_acc = ACC_NONE;
        if (csr_addr_i[6:5] == 2'b00) begin
            if (csr_addr_i[11:8] == 4'hB)      w_acc = ACC_MCNT;
            else if (csr_addr_i[11:8] == 4'hC) w_acc = ACC_UCNT;
        end
        if (csr_addr_i == CSR_MCOUNTEREN)    w_acc = ACC_CEN;
        if (csr_addr_i == CSR_MCOUNTINHIBIT) w_acc = ACC_INH;
    end

    always_comb begin
        w_err    = 1'b1;
        w_rd_val = '0;
        case (w_acc)
            // Index 1 is CSR_TIME in the user space and unmapped in the machine space.
            ACC_MCNT: w_err = !priv_m_i || (w_idx == 5'd1);
            ACC_UCNT: w_err = csr_we_i || (w_idx == 5'd1)
                              || (!priv_m_i && !mcounteren_q[w_idx]);
            ACC_CEN,
            ACC_INH:  w_err = !priv_m_i;
            default:  w_err = 1'b1;
        endcase
        case (w_acc)
            ACC_MCNT,
            ACC_UCNT: w_rd_val = w_hi ? XLEN'(w_cnt_sel[CNT_WIDTH-1:XLEN])
                                      : w_cnt_sel[XLEN-1:0];
            ACC_CEN:  w_rd_val = mcounteren_q;
            ACC_INH:  w_rd_val = mcountinhibit_q;
            default:  w_rd_val = '0;
        endcase
    end

    assign w_wr_ok  = csr_req_i & csr_we_i & ~w_err;
    assign w_cnt_wr = w_wr_ok & (w_acc == ACC_MCNT);

    always_comb begin
        mcounteren_d    = mcounteren_q;
        mcountinhibit_d = mcountinhibit_q;
        if (w_wr_ok && w_acc == ACC_CEN) mcounteren_d    = csr_wdata_i & c_CSR_MASK;
        if (w_wr_ok && w_acc == ACC_INH) mcountinhibit_d = csr_wdata_i & c_CSR_MASK;

        rvalid_d = csr_req_i;
        err_d    = csr_req_i & w_err;
        rdata_d  = (csr_req_i && !csr_we_i && !w_err) ? w_rd_val : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcounteren_q    <= '0;
            mcountinhibit_q <= '0;
            rvalid_q        <= 1'b0;
            rdata_q         <= '0;
            err_q           <= 1'b0;
        end else begin
            mcounteren_q    <= mcounteren_d;
            mcountinhibit_q <= mcountinhibit_d;
            rvalid_q        <= rvalid_d;
            rdata_q         <= rdata_d;
            err_q           <= err_d;
        end
    end

    assign csr_rvalid_o = rvalid_q;
    assign csr_rdata_o  = rdata_q;
    assign csr_err_o    = err_q;

endmodule : hpm_counter_unit
`default_nettype wire

// File: tb/tb_hpm_counter_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hpm_counter_unit
// Description : Self-checking bench for hpm_counter_unit. A behavioural model
//               of the counters and CSR rules predicts every response; a
//               compare process checks it on each falling edge, and literal
//               expectations pin the model at key points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hpm_counter_unit;

    localparam int XLEN         = 32;
    localparam int CNT_WIDTH    = 64;
    localparam int NB_HPM       = 14;
    localparam int RETIRE_WIDTH = 2;
    localparam logic [31:0] c_MASK = 32'h0001_FFFD;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [13:0] ev;
    logic [1:0]  ret;
    logic        priv, req, we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        rvalid, err;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_errors = 0;

    longint unsigned m_cnt [32];
    logic [31:0]     m_en, m_inh;
    logic            exp_valid, exp_err;
    logic [31:0]     exp_rdata;

    always #5 clk = ~clk;

    hpm_counter_unit #(
        .XLEN(XLEN), .CNT_WIDTH(CNT_WIDTH), .NB_HPM(NB_HPM), .RETIRE_WIDTH(RETIRE_WIDTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .event_i(ev), .retire_cnt_i(ret),
        .priv_m_i(priv), .csr_req_i(req), .csr_we_i(we), .csr_addr_i(addr),
        .csr_wdata_i(wdata), .csr_rvalid_o(rvalid), .csr_rdata_o(rdata),
        .csr_err_o(err)
    );

    function automatic bit implemented(int i);
        return (i == 0) || (i == 2) || (i >= 3 && i <= NB_HPM + 2);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_en      = '0;
        m_inh     = '0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        exp_rdata = '0;
    endtask

    // Predict the response to the current inputs, advance the model, clock once.
    task automatic tick();
        bit          in_m, in_u, hi, e;
        int          idx;
        logic [31:0] r;
        idx  = int'(addr[4:0]);
        hi   = addr[7];
        in_m = addr inside {[12'hB00:12'hB1F], [12'hB80:12'hB9F]};
        in_u = addr inside {[12'hC00:12'hC1F], [12'hC80:12'hC9F]};
        r    = '0;
        e    = 1'b1;
        if (in_m)                                e = !priv || idx == 1;
        else if (in_u)                           e = we || idx == 1 || (!priv && !m_en[idx]);
        else if (addr == 12'h306 || addr == 12'h320) e = !priv;
        if (!req) e = 1'b0;
        if (req && !e && !we) begin
            if (in_m || in_u)         r = hi ? m_cnt[idx][63:32] : m_cnt[idx][31:0];
            else if (addr == 12'h306) r = m_en;
            else                      r = m_inh;
        end
        for (int i = 0; i < 32; i++) begin
            if (implemented(i)) begin
                if (req && we && !e && in_m && idx == i) begin
                    if (hi) m_cnt[i][63:32] = wdata;
                    else    m_cnt[i][31:0]  = wdata;
                end else if (!m_inh[i]) begin
                    if (i == 0)      m_cnt[i] = m_cnt[i] + 1;
                    else if (i == 2) m_cnt[i] = m_cnt[i] + longint'(ret);
                    else             m_cnt[i] = m_cnt[i] + longint'(ev[i-3]);
                end
            end
        end
        if (req && we && !e) begin
            if (addr == 12'h306) m_en  = wdata & c_MASK;
            if (addr == 12'h320) m_inh = wdata & c_MASK;
        end
        @(posedge clk);
        #1;
        exp_valid = req;
        exp_err   = req && e;
        exp_rdata = r;
    endtask

    task automatic csr(input bit w, input logic [11:0] a, input logic [31:0] d);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        tick();
        req   = 1'b0;
        we    = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            n_checks++;
            if (rvalid !== exp_valid) begin
                n_errors++;
                $display("FAIL resp_valid actual=%b expected=%b", rvalid, exp_valid);
            end
            if (exp_valid) begin
                n_checks++;
                if (rdata !== exp_rdata || err !== exp_err) begin
                    n_errors++;
                    $display("FAIL resp_data addr=%h actual=%h/%b expected=%h/%b",
                             addr, rdata, err, exp_rdata, exp_err);
                end
            end
        end
    end

    initial begin
        logic [11:0] tbl [12];
        tbl = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB10,
                12'hB83, 12'hB90, 12'hC00, 12'hC03, 12'h320, 12'h306};
        reset_n = 1'b0;
        ev = '0; ret = '0; priv = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        model_reset();
        #12;
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        @(negedge clk); #1;
        reset_n = 1'b1;

        // mcycle runs 100 cycles, then an asynchronous reset mid-cycle.
        repeat (100) tick();
        csr(1'b0, 12'hB00, '0);
        check("mcycle_100", rdata, 32'd100);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_rvalid", 32'(rvalid), 32'd0);
        check("async_rdata", rdata, 32'd0);
        @(negedge clk); #1;
        reset_n = 1'b1;
        csr(1'b0, 12'hB00, '0);
        check("post_rst_mcycle", rdata, 32'd0);
        csr(1'b0, 12'hB02, '0);
        check("post_rst_minstret", rdata, 32'd0);
        csr(1'b0, 12'hB83, '0);
        check("post_rst_hpm3h", rdata, 32'd0);

        // Wrap through a high-half then low-half write.
        csr(1'b1, 12'hB80, 32'hFFFF_FFFF);
        csr(1'b1, 12'hB00, 32'hFFFF_FFFE);
        repeat (2) tick();
        csr(1'b0, 12'hB00, '0);
        check("wrap_lo", rdata, 32'd0);
        csr(1'b0, 12'hB80, '0);
        check("wrap_hi", rdata, 32'd0);

        // minstret with multi-retire and inhibit.
        ret = 2'd2;
        repeat (5) tick();
        ret = 2'd0;
        csr(1'b0, 12'hB02, '0);
        check("minstret_10", rdata, 32'd10);
        csr(1'b1, 12'h320, 32'd4);
        ret = 2'd2;
        repeat (3) tick();
        ret = 2'd0;
        csr(1'b0, 12'hB02, '0);
        check("minstret_inh", rdata, 32'd10);
        csr(1'b0, 12'h320, '0);
        check("inhibit_rd", rdata, 32'd4);
        csr(1'b1, 12'h320, '0);

        // A write beats a same-cycle event.
        ev = 14'h1;
        csr(1'b1, 12'hB03, 32'd5);
        ev = '0;
        csr(1'b0, 12'hB03, '0);
        check("write_beats_ev", rdata, 32'd5);
        ev = 14'h1;
        tick();
        ev = '0;
        csr(1'b0, 12'hB03, '0);
        check("event_after_wr", rdata, 32'd6);

        // User-mode gating.
        priv = 1'b0;
        csr(1'b0, 12'hC00, '0);
        check("user_c00_err", 32'(err), 32'd1);
        check("user_c00_rdata", rdata, 32'd0);
        priv = 1'b1;
        csr(1'b1, 12'h306, 32'd1);
        priv = 1'b0;
        csr(1'b0, 12'hC00, '0);
        check("user_c00_ok", 32'(err), 32'd0);
        csr(1'b1, 12'hC00, 32'd123);
        check("user_c00_wr", 32'(err), 32'd1);
        csr(1'b0, 12'hC00, '0);
        csr(1'b0, 12'hC02, '0);
        check("user_c02_err", 32'(err), 32'd1);
        csr(1'b0, 12'hB00, '0);
        check("user_b00_err", 32'(err), 32'd1);
        csr(1'b1, 12'h320, 32'd8);
        check("user_inh_err", 32'(err), 32'd1);
        priv = 1'b1;

        // Illegal and reserved addresses.
        csr(1'b0, 12'hC01, '0);
        check("time_err", 32'(err), 32'd1);
        csr(1'b1, 12'hF11, '0);
        check("f11_wr_err", 32'(err), 32'd1);
        csr(1'b0, 12'hB1F, '0);
        check("b1f_err", 32'(err), 32'd0);
        check("b1f_rdata", rdata, 32'd0);
        csr(1'b1, 12'hB1F, 32'd55);
        check("b1f_wr_err", 32'(err), 32'd0);
        csr(1'b0, 12'hB01, '0);
        check("b01_err", 32'(err), 32'd1);
        csr(1'b0, 12'h7C0, '0);
        check("unmapped_err", 32'(err), 32'd1);
        csr(1'b1, 12'h320, 32'hFFFF_FFFF);
        csr(1'b0, 12'h320, '0);
        check("inhibit_mask", rdata, 32'h0001_FFFD);

        // Inhibited hpm3 ignores events, then resumes after clearing.
        csr(1'b1, 12'h320, 32'd8);
        ev = 14'h1;
        repeat (3) tick();
        ev = '0;
        csr(1'b0, 12'hB03, '0);
        check("hpm3_inh", rdata, 32'd6);
        ev = 14'h1;
        csr(1'b1, 12'h320, '0);
        repeat (2) tick();
        ev = '0;
        csr(1'b0, 12'hB03, '0);

        // Mixed traffic with events and retires, plus half writes.
        csr(1'b1, 12'hB90, 32'h1234_5678);
        csr(1'b1, 12'hB10, 32'hFFFF_FFF0);
        for (int i = 0; i < 36; i++) begin
            ev  = 14'($urandom);
            ret = 2'($urandom_range(0, 2));
            csr(1'b0, tbl[i % 12], '0);
        end
        ev = '0; ret = '0;
        tick();
        @(negedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_hpm_counter_unit
`default_nettype wire

// File: doc/hpm_counter_unit.md
Name: hpm_counter_unit

Overview:
Machine/user performance-counter block: mcycle, minstret and NB_HPM programmable-event counters (mhpmcounter3..), each CNT_WIDTH wide, plus mcountinhibit and mcounteren. It sits beside the CSR file and serves CSR reads and writes over a one-cycle request/response port. It generalises the fixed counter address map to a parametrised counter count and width, multi-retire instret, inhibit control and user-mode access gating.

Parameters:
XLEN, 32, CSR data width
CNT_WIDTH, 64, counter width; must be > XLEN and <= 2*XLEN
NB_HPM, 14, implemented event counters starting at index 3 (3..NB_HPM+2), max 29
RETIRE_WIDTH, 2, max instructions retired per cycle (FRONTEND_WIDTH)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
event_i  in  NB_HPM  per-cycle event pulses; bit k increments counter 3+k
retire_cnt_i  in  $clog2(RETIRE_WIDTH+1)  instructions retired this cycle
priv_m_i  in  1  1 = machine mode, 0 = user mode
csr_req_i  in  1  CSR access valid this cycle
csr_we_i  in  1  1 = write, 0 = read
csr_addr_i  in  12  CSR address (csr_reg_t plus high-half constants)
csr_wdata_i  in  XLEN  write data
csr_rvalid_o  out  1  response valid, one cycle after csr_req_i
csr_rdata_o  out  XLEN  read data (0 on error or write)
csr_err_o  out  1  illegal access, qualified by csr_rvalid_o

Behaviour:
- Reset (async, reset_n=0): all counters 0, mcountinhibit 0, mcounteren 0, csr_rvalid_o 0, csr_rdata_o 0, csr_err_o 0.
- Increment, every cycle: mcycle +1 unless inhibit[0]. minstret + retire_cnt_i unless inhibit[2]. hpm[i] + event_i[i-3] unless inhibit[i]. Arithmetic is modulo 2^CNT_WIDTH, so all-ones + 1 wraps to 0.
- Address decode:
  - Low half: MCYCLE B00, MINSTRET B02, MHPM B03+k.
  - High half (bits CNT_WIDTH-1:XLEN, zero-extended): B80, B82, B83+k.
  - User shadows, read-only: C00/C02/C03+k and high halves C80/C82/C83+k.
  - MCOUNTEREN 306 and MCOUNTINHIBIT 320, both XLEN wide; bit1 is read-only 0, and bits above NB_HPM+2 are read-only 0.
- Handshake:
  - csr_req_i may be asserted every cycle.
  - The response registers on the next edge: csr_rvalid_o=1 for exactly one cycle.
  - Read data is the value at the request cycle, before that cycle's increment.
- Writes:
  - Machine-mode write to a counter half replaces that half and keeps the other half.
  - Write beats increment: the written counter does not increment in the write cycle, and the next-cycle value equals the written value exactly.
  - Writes to reserved counters (index > NB_HPM+2, up to 31) are ignored with no error; reads of them return 0.
- Errors (csr_err_o=1, rdata=0, no state change):
  - Any access with priv_m_i=0 to B**, 3**, or 306/320.
  - Any write to C** or F**.
  - User read of a C** shadow whose mcounteren bit (index = addr[4:0]) is 0.
  - CSR_TIME C01/C81 (not implemented).
  - Any address not in the map.
- A counter with inhibit set still accepts writes.
- Clearing an inhibit bit resumes counting from the cycle after the write response.

Decomposition:
- Package riscv gains:
  - CSR_MCOUNTINHIBIT=12'h320.
  - High-half constants CSR_MCYCLEH=12'hB80, CSR_MINSTRETH=12'hB82, CSR_MHPMCOUNTER3H=12'hB83, CSR_CYCLEH=12'hC80, CSR_INSTRETH=12'hC82, CSR_HPMCOUNTER3H=12'hC83.
  - HPM_BASE_IDX=3.
- Sub-module hpm_counter: one CNT_WIDTH counter with inc amount, inhibit, and low/high write enables. It is instantiated NB_HPM+2 times.
- The top level holds decode, permission checks, mcounteren/mcountinhibit and the response register.

Test Plan:
- Reset mid-count: let mcycle run 100 cycles, assert reset_n=0 asynchronously → all counters read 0 and csr_rvalid_o=0 immediately, before the next edge.
- Wrap / high-half write: M-mode write B80=FFFFFFFF, then B00=FFFFFFFE, then idle 2 cycles → read B00=00000000 and B80=00000000.
- minstret with inhibit: retire_cnt_i=2 for 5 cycles → minstret=10. Set mcountinhibit bit2, retire 2 for 3 cycles → still 10.
- Write beats event: same cycle, event_i[0]=1 and write B03=5 → next-cycle read B03=5; event pulse the cycle after → 6.
- User gating:
  - priv_m_i=0, mcounteren=0, read C00 → csr_err_o=1, rdata=0.
  - Set mcounteren=1 → read C00 returns mcycle, err=0.
  - User write C00 → err=1, value unchanged.
- Illegal addresses: read C01, write F11, and read B1F with NB_HPM=14 → C01 err=1; F11 err=1; B1F err=0, rdata=0.
